// File: rtl/axi4_w_sync.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_w_sync
//  Description : W-channel companion stage for the AXI4 write path. Holds the
//                AWLEN of every AW handshake in a small length FIFO, releases
//                W beats only against an announced burst, regenerates WLAST
//                from AWLEN, flags WLAST mismatches and drives one registered
//                W stage towards the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_w_sync #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 4,
    parameter int AW_DEPTH       = 4
) (
    input  logic                          axi4_aclk,
    input  logic                          axi4_arstn,

    // Burst length announcement from the AW side
    input  logic                          awlen_valid,
    output logic                          awlen_ready,
    input  logic [7:0]                    awlen,

    // W channel from the master
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi4_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi4_wstrb,
    input  logic                          s_axi4_wlast,
    input  logic [AXI_USER_WIDTH-1:0]     s_axi4_wuser,
    input  logic                          s_axi4_wvalid,
    output logic                          s_axi4_wready,

    // W channel towards the slave
    output logic [AXI_DATA_WIDTH-1:0]     m_axi4_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi4_wstrb,
    output logic                          m_axi4_wlast,
    output logic [AXI_USER_WIDTH-1:0]     m_axi4_wuser,
    output logic                          m_axi4_wvalid,
    input  logic                          m_axi4_wready,

    // Status
    output logic                          wlast_err,
    output logic [$clog2(AW_DEPTH):0]     aw_outstanding
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_PTR_W = $clog2(AW_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam int                 c_STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(AW_DEPTH);

    // ------------------------------------------------------------------------
    // Length FIFO state
    // ------------------------------------------------------------------------
    logic [7:0]            r_len_mem [AW_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    // ------------------------------------------------------------------------
    // Beat tracking and output register state
    // ------------------------------------------------------------------------
    logic [7:0]                 r_beat_cnt;
    logic                       r_wvalid;
    logic                       r_wlast;
    logic [AXI_DATA_WIDTH-1:0]  r_wdata;
    logic [c_STRB_W-1:0]        r_wstrb;
    logic [AXI_USER_WIDTH-1:0]  r_wuser;
    logic                       r_wlast_err;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic       w_full;
    logic       w_head_ok;
    logic [7:0] w_head_len;
    logic       w_slot_free;
    logic       w_accept;
    logic       w_beat_is_last;
    logic       w_push;
    logic       w_pop;

    assign w_full         = (r_count == c_DEPTH);
    assign w_head_ok      = (r_count != '0);
    // Only meaningful while the FIFO is non-empty; every use is gated by w_head_ok.
    assign w_head_len     = r_len_mem[r_rd_ptr];

    // The output slot can take a new beat if it is empty or being drained now.
    assign w_slot_free    = !r_wvalid || m_axi4_wready;
    assign w_accept       = s_axi4_wvalid && w_head_ok && w_slot_free;
    assign w_beat_is_last = (r_beat_cnt == w_head_len);

    // A length pushed this cycle only becomes visible at the head next cycle.
    assign w_push         = awlen_valid && !w_full;
    assign w_pop          = w_accept && w_beat_is_last;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign awlen_ready    = !w_full;
    assign s_axi4_wready  = w_head_ok && w_slot_free;
    assign m_axi4_wdata   = r_wdata;
    assign m_axi4_wstrb   = r_wstrb;
    assign m_axi4_wlast   = r_wlast;
    assign m_axi4_wuser   = r_wuser;
    assign m_axi4_wvalid  = r_wvalid;
    assign wlast_err      = r_wlast_err;
    assign aw_outstanding = r_count;

    // Length storage; entries beyond the occupancy count are never read, so
    // the array itself needs no reset.
    always_ff @(posedge axi4_aclk) begin
        if (w_push) begin
            r_len_mem[r_wr_ptr] <= awlen;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as depth is 2^n.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat counter within the head burst; restarts at the AWLEN match so a
    // 256-beat burst never needs a ninth bit.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (w_beat_is_last) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Single registered W stage; payload only changes on accept so it holds
    // steady under slave backpressure.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wuser  <= '0;
        end else if (w_accept) begin
            r_wvalid <= 1'b1;
            r_wlast  <= w_beat_is_last;
            r_wdata  <= s_axi4_wdata;
            r_wstrb  <= s_axi4_wstrb;
            r_wuser  <= s_axi4_wuser;
        end else if (m_axi4_wready) begin
            r_wvalid <= 1'b0;
        end
    end

    // One-cycle pulse when the master's WLAST disagrees with the AWLEN count;
    // the burst itself is always framed by AWLEN.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_wlast_err <= 1'b0;
        end else begin
            r_wlast_err <= w_accept && (s_axi4_wlast != w_beat_is_last);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_w_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_w_sync
//  Description : Self-checking bench for axi4_w_sync with a scoreboard of
//                expected output beats and a reference model of burst framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_w_sync;

    localparam int c_DW    = 64;
    localparam int c_UW    = 4;
    localparam int c_DEPTH = 4;
    localparam int c_EW    = c_DW + c_DW / 8 + c_UW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              awlen_valid = 1'b0;
    logic              awlen_ready;
    logic [7:0]        awlen = 8'd0;
    logic [c_DW-1:0]   s_wdata = '0;
    logic [c_DW/8-1:0] s_wstrb = '0;
    logic              s_wlast = 1'b0;
    logic [c_UW-1:0]   s_wuser = '0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [c_DW-1:0]   m_wdata;
    logic [c_DW/8-1:0] m_wstrb;
    logic              m_wlast;
    logic [c_UW-1:0]   m_wuser;
    logic              m_wvalid;
    logic              m_wready = 1'b1;
    logic              wlast_err;
    logic [2:0]        aw_outstanding;

    int errors = 0;
    int checks = 0;

    // Scoreboard and reference model state (owned by the monitor)
    logic [c_EW-1:0] exp_q[$];
    int              len_q[$];
    int              mdl_cnt = 0;
    logic            exp_err = 1'b0;
    logic            stall_prev = 1'b0;
    logic [c_EW-1:0] prev_fields = '0;

    // Per-test statistics
    int out_cnt = 0;
    int last_pos_q[$];
    int err_pulses = 0;

    bit   bp_rand = 1'b0;
    logic wready_force = 1'b1;

    always #5 clk = ~clk;

    axi4_w_sync #(
        .AXI_DATA_WIDTH (c_DW),
        .AXI_USER_WIDTH (c_UW),
        .AW_DEPTH       (c_DEPTH)
    ) dut (
        .axi4_aclk      (clk),
        .axi4_arstn     (rst_n),
        .awlen_valid    (awlen_valid),
        .awlen_ready    (awlen_ready),
        .awlen          (awlen),
        .s_axi4_wdata   (s_wdata),
        .s_axi4_wstrb   (s_wstrb),
        .s_axi4_wlast   (s_wlast),
        .s_axi4_wuser   (s_wuser),
        .s_axi4_wvalid  (s_wvalid),
        .s_axi4_wready  (s_wready),
        .m_axi4_wdata   (m_wdata),
        .m_axi4_wstrb   (m_wstrb),
        .m_axi4_wlast   (m_wlast),
        .m_axi4_wuser   (m_wuser),
        .m_axi4_wvalid  (m_wvalid),
        .m_axi4_wready  (m_wready),
        .wlast_err      (wlast_err),
        .aw_outstanding (aw_outstanding)
    );

    // Slave ready: fixed level or 50% random toggling
    always @(posedge clk) begin
        #1;
        m_wready = bp_rand ? 1'($urandom_range(0, 1)) : wready_force;
    end

    // Monitor: compares outputs against the scoreboard, checks hold under
    // stall and the error pulse, then advances the reference model.
    always @(negedge clk) begin
        logic [c_EW-1:0] cur;
        logic [c_EW-1:0] e;
        logic            mlast;
        cur = {m_wdata, m_wstrb, m_wuser, m_wlast};
        if (!rst_n) begin
            exp_q.delete();
            len_q.delete();
            mdl_cnt    = 0;
            exp_err    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (wlast_err !== exp_err) begin
                errors++;
                $display("FAIL wlast_err: got %b want %b at %0t", wlast_err, exp_err, $time);
            end
            if (wlast_err === 1'b1) err_pulses++;
            if (stall_prev) begin
                checks++;
                if (m_wvalid !== 1'b1 || cur !== prev_fields) begin
                    errors++;
                    $display("FAIL hold: got valid=%b fields=%h want valid=1 fields=%h", m_wvalid, cur, prev_fields);
                end
            end
            if (m_wvalid === 1'b1 && m_wready === 1'b1) begin
                out_cnt++;
                if (m_wlast === 1'b1) last_pos_q.push_back(out_cnt);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got unexpected beat %h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL out_beat: got %h want %h", cur, e);
                    end
                end
            end
            stall_prev  = (m_wvalid === 1'b1) && (m_wready !== 1'b1);
            prev_fields = cur;
            exp_err     = 1'b0;
            if (s_wvalid === 1'b1 && s_wready === 1'b1) begin
                checks++;
                if (len_q.size() == 0) begin
                    errors++;
                    $display("FAIL gate: got beat accepted want no accept (no length queued)");
                end else begin
                    mlast = (mdl_cnt == len_q[0]);
                    exp_q.push_back({s_wdata, s_wstrb, s_wuser, mlast});
                    exp_err = (s_wlast != mlast);
                    if (mlast) begin
                        void'(len_q.pop_front());
                        mdl_cnt = 0;
                    end else begin
                        mdl_cnt++;
                    end
                end
            end
            if (awlen_valid === 1'b1 && awlen_ready === 1'b1) len_q.push_back(int'(awlen));
        end
    end

    function automatic logic [c_DW-1:0] beat_data(input int base, input int idx);
        return {32'(base), 32'(idx)} ^ 64'h5A5A_0000_0000_C3C3;
    endfunction

    task automatic set_beat(input int base, input int idx, input logic wl);
        logic [c_DW-1:0] d;
        d        = beat_data(base, idx);
        s_wvalid = 1'b1;
        s_wdata  = d;
        s_wstrb  = d[7:0] ^ d[15:8];
        s_wuser  = d[3:0] ^ d[35:32];
        s_wlast  = wl;
    endtask

    // Sends beats first..stop-1 of an nb-beat burst; WLAST on the true last
    // beat and additionally on beat index 'extra'.
    task automatic send_burst(input int nb, input int first, input int stop,
                              input int base, input int extra);
        bit got;
        for (int i = first; i < stop; i++) begin
            @(posedge clk); #1;
            set_beat(base, i, (i == nb - 1) || (i == extra));
            got = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (s_wready === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no s_axi4_wready for beat %0d want ready within 200 cycles", i);
                return;
            end
        end
    endtask

    task automatic w_idle();
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic push_len(input logic [7:0] l, input logic exp_ready, output logic wr_seen);
        @(posedge clk); #1;
        awlen_valid = 1'b1;
        awlen       = l;
        @(negedge clk);
        wr_seen = s_wready;
        checks++;
        if (awlen_ready !== exp_ready) begin
            errors++;
            $display("FAIL awlen_ready: got %b want %b (len %0d)", awlen_ready, exp_ready, l);
        end
        @(posedge clk); #1;
        awlen_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && m_wvalid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_stats();
        out_cnt    = 0;
        err_pulses = 0;
        last_pos_q.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_wvalid, m_wlast, m_wdata, m_wstrb, m_wuser, wlast_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h s=%h u=%h e=%b want all 0",
                     m_wvalid, m_wlast, m_wdata, m_wstrb, m_wuser, wlast_err);
        end
        checks++;
        if (aw_outstanding !== 3'd0 || awlen_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got outstanding=%0d awlen_ready=%b want 0 and 1", aw_outstanding, awlen_ready);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_empty_gate();
        @(posedge clk); #1;
        set_beat(1, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (s_wready !== 1'b0 || m_wvalid !== 1'b0) begin
                errors++;
                $display("FAIL empty_gate: got wready=%b m_wvalid=%b want 0 and 0 (cycle %0d)", s_wready, m_wvalid, i);
            end
        end
        w_idle();
    endtask

    task automatic test_basic_burst();
        logic wr;
        bit   ok;
        clear_stats();
        @(posedge clk); #1;
        set_beat(10, 0, 1'b0);
        push_len(8'd3, 1'b1, wr);
        checks++;
        if (wr !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: got s_axi4_wready=%b in push cycle want 0", wr);
        end
        // Next cycle the length gates beat 0
        @(negedge clk);
        checks++;
        if (s_wready !== 1'b1 || aw_outstanding !== 3'd1) begin
            errors++;
            $display("FAIL basic_gate: got wready=%b outstanding=%0d want 1 and 1", s_wready, aw_outstanding);
        end
        send_burst(4, 1, 4, 10, -1);
        w_idle();
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_drain: got pending=%0d want 0", exp_q.size()); end
        checks++;
        if (out_cnt != 4 || last_pos_q.size() != 1 || aw_outstanding !== 3'd0 || err_pulses != 0) begin
            errors++;
            $display("FAIL basic_summary: got beats=%0d lasts=%0d outstanding=%0d errs=%0d want 4 1 0 0",
                     out_cnt, last_pos_q.size(), aw_outstanding, err_pulses);
        end else begin
            checks++;
            if (last_pos_q[0] != 4) begin
                errors++;
                $display("FAIL basic_last_pos: got %0d want 4", last_pos_q[0]);
            end
        end
    endtask

    task automatic test_fifo_wrap();
        logic wr;
        bit   ok;
        int   want_pos[4];
        want_pos = '{1, 4, 260, 262};
        clear_stats();
        push_len(8'd0,   1'b1, wr);
        push_len(8'd2,   1'b1, wr);
        push_len(8'd255, 1'b1, wr);
        push_len(8'd1,   1'b1, wr);
        push_len(8'd9,   1'b0, wr);
        @(negedge clk);
        checks++;
        if (aw_outstanding !== 3'd4 || awlen_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: got outstanding=%0d awlen_ready=%b want 4 and 0", aw_outstanding, awlen_ready);
        end
        send_burst(1,   0, 1,   100, -1);
        send_burst(3,   0, 3,   200, -1);
        send_burst(256, 0, 256, 300, -1);
        send_burst(2,   0, 2,   400, -1);
        w_idle();
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_drain: got pending=%0d want 0", exp_q.size()); end
        checks++;
        if (out_cnt != 262 || aw_outstanding !== 3'd0 || awlen_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count: got beats=%0d outstanding=%0d ready=%b want 262 0 1",
                     out_cnt, aw_outstanding, awlen_ready);
        end
        checks++;
        if (last_pos_q.size() != 4) begin
            errors++;
            $display("FAIL wrap_lasts: got %0d last flags want 4", last_pos_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (last_pos_q[i] != want_pos[i]) begin
                    errors++;
                    $display("FAIL wrap_last_pos%0d: got %0d want %0d", i, last_pos_q[i], want_pos[i]);
                end
            end
        end
    endtask

    task automatic test_wlast_err();
        logic wr;
        bit   ok;
        clear_stats();
        push_len(8'd2, 1'b1, wr);
        // Early WLAST on beat 2; beat 3 also carries WLAST, so only beat 2 mismatches
        send_burst(3, 0, 3, 500, 1);
        w_idle();
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL err_drain: got pending=%0d want 0", exp_q.size()); end
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL err_pulses: got %0d want 1", err_pulses);
        end
        checks++;
        if (last_pos_q.size() != 1 || out_cnt != 3) begin
            errors++;
            $display("FAIL err_framing: got lasts=%0d beats=%0d want 1 and 3", last_pos_q.size(), out_cnt);
        end else begin
            checks++;
            if (last_pos_q[0] != 3) begin
                errors++;
                $display("FAIL err_last_pos: got %0d want 3", last_pos_q[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic wr;
        bit   ok;
        clear_stats();
        push_len(8'd15, 1'b1, wr);
        bp_rand = 1'b1;
        send_burst(16, 0, 16, 600, -1);
        w_idle();
        drain(ok);
        bp_rand = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain: got pending=%0d want 0", exp_q.size()); end
        checks++;
        if (out_cnt != 16 || last_pos_q.size() != 1 || aw_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL bp_count: got beats=%0d lasts=%0d outstanding=%0d want 16 1 0",
                     out_cnt, last_pos_q.size(), aw_outstanding);
        end
    endtask

    task automatic test_reset_midburst();
        logic wr;
        bit   ok;
        clear_stats();
        wready_force = 1'b1;
        push_len(8'd7, 1'b1, wr);
        send_burst(8, 0, 3, 700, -1);
        @(posedge clk); #1;
        checks++;
        if (m_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prereset: got m_wvalid=%b want 1", m_wvalid);
        end
        rst_n    = 1'b0;
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        #1;
        checks++;
        if ({m_wvalid, m_wlast, m_wdata, m_wstrb, m_wuser, wlast_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%b l=%b d=%h s=%h u=%h e=%b want all 0",
                     m_wvalid, m_wlast, m_wdata, m_wstrb, m_wuser, wlast_err);
        end
        checks++;
        if (aw_outstanding !== 3'd0 || awlen_ready !== 1'b1 || s_wready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_fifo: got outstanding=%0d ready=%b wready=%b want 0 1 0",
                     aw_outstanding, awlen_ready, s_wready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        push_len(8'd1, 1'b1, wr);
        send_burst(2, 0, 2, 800, -1);
        w_idle();
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL post_reset_drain: got pending=%0d want 0", exp_q.size()); end
        checks++;
        if (out_cnt != 2 || last_pos_q.size() != 1 || aw_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_burst: got beats=%0d lasts=%0d outstanding=%0d want 2 1 0",
                     out_cnt, last_pos_q.size(), aw_outstanding);
        end else begin
            checks++;
            if (last_pos_q[0] != 2) begin
                errors++;
                $display("FAIL post_reset_last_pos: got %0d want 2", last_pos_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_gate();
        test_basic_burst();
        test_fifo_wrap();
        test_wlast_err();
        test_backpressure();
        test_reset_midburst();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
